// File: rtl/ksa.sv
// ARC4 key-scheduling stage: permutes the identity-filled S memory using the key,
// one swap per six-cycle iteration over a single-port synchronous-read memory.
module ksa #(
   parameter int KEY_BYTES = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   output logic                   rdy,
   input  logic [8*KEY_BYTES-1:0] key,
   output logic [7:0]             addr,
   input  logic [7:0]             rddata,
   output logic [7:0]             wrdata,
   output logic                   wren
);

   localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD_I = 3'd1,
      LT_I = 3'd2,
      RD_J = 3'd3,
      LT_J = 3'd4,
      WR_I = 3'd5,
      WR_J = 3'd6
   } state_t;

   state_t                 state, state_nxt;
   logic [7:0]             i_q, j_q;
   logic [7:0]             si_q, sj_q;
   logic [8*KEY_BYTES-1:0] key_q;
   logic [KIDX_W-1:0]      kidx_q;

   function automatic logic [7:0] wrap_add(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c);
      wrap_add = a + b + c;
   endfunction

   // key byte 0 sits in the most-significant byte of the key word
   function automatic logic [7:0] key_byte(input logic [8*KEY_BYTES-1:0] k,
                                           input logic [KIDX_W-1:0] idx);
      key_byte = '0;
      for (int b = 0; b < KEY_BYTES; b++) begin
         if (idx == b[KIDX_W-1:0]) key_byte = k[8*(KEY_BYTES-1-b) +: 8];
      end
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         i_q    <= '0;
         j_q    <= '0;
         key_q  <= '0;
         kidx_q <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (en) begin
                  key_q  <= key;
                  i_q    <= '0;
                  j_q    <= '0;
                  kidx_q <= '0;
               end
            end
            LT_I: j_q <= wrap_add(j_q, rddata, key_byte(key_q, kidx_q));
            WR_J: begin
               kidx_q <= (kidx_q == KIDX_W'(KEY_BYTES-1)) ? '0 : kidx_q + 1'b1;
               if (i_q != 8'hFF) i_q <= i_q + 8'd1;
            end
            default: ;
         endcase
      end
   end

   // swap operands are pure data: captured in the latch states, never reset
   always_ff @(posedge clk) begin
      if (state == LT_I) si_q <= rddata;
      if (state == LT_J) sj_q <= rddata;
   end

   always_comb begin
      state_nxt = IDLE;
      rdy       = 1'b0;
      addr      = 8'd0;
      wrdata    = 8'd0;
      wren      = 1'b0;
      case (state)
         IDLE: begin
            rdy       = 1'b1;
            state_nxt = en ? RD_I : IDLE;
         end
         RD_I: begin
            addr      = i_q;
            state_nxt = LT_I;
         end
         LT_I: begin
            addr      = i_q;
            state_nxt = RD_J;
         end
         RD_J: begin
            addr      = j_q;
            state_nxt = LT_J;
         end
         LT_J: begin
            addr      = j_q;
            state_nxt = WR_I;
         end
         WR_I: begin
            addr      = i_q;
            wrdata    = sj_q;
            wren      = 1'b1;
            state_nxt = WR_J;
         end
         WR_J: begin
            addr      = j_q;
            wrdata    = si_q;
            wren      = 1'b1;
            state_nxt = (i_q == 8'hFF) ? IDLE : RD_I;
         end
         default: begin
            rdy       = 1'bx;
            addr      = 8'hxx;
            wrdata    = 8'hxx;
            wren      = 1'bx;
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_ksa.sv
// Scoreboard bench for ksa: expected memory writes are queued at stimulus time and
// a negedge monitor pops and compares each write the DUT issues.
module tb_ksa;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        rdy;
   logic [23:0] key;
   logic [7:0]  addr;
   logic [7:0]  rddata;
   logic [7:0]  wrdata;
   logic        wren;

   logic [7:0]  mem [256];
   logic [7:0]  sm  [256];
   logic [15:0] exp_q [$];
   logic [15:0] mon_e;
   int          checks = 0;
   int          errors = 0;
   int          low;
   int          bad;

   ksa #(.KEY_BYTES(3)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .rdy    (rdy),
      .key    (key),
      .addr   (addr),
      .rddata (rddata),
      .wrdata (wrdata),
      .wren   (wren)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // single-port synchronous-read S memory
   initial begin
      rddata = 8'd0;
      forever @(posedge clk) begin
         rddata <= mem[addr];
         if (wren === 1'b1) mem[addr] <= wrdata;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", nm, act, req);
      end
   endtask

   initial begin
      forever @(negedge clk) begin
         if (wren === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write addr %0d data %0d expected none", addr, wrdata);
            end else begin
               mon_e = exp_q.pop_front();
               chk("wr_addr", {24'd0, addr}, {24'd0, mon_e[15:8]});
               chk("wr_data", {24'd0, wrdata}, {24'd0, mon_e[7:0]});
            end
         end
      end
   end

   task automatic push(input logic [7:0] a, input logic [7:0] d);
      exp_q.push_back({a, d});
   endtask

   task automatic fill_identity();
      for (int k = 0; k < 256; k++) begin
         mem[k] = 8'(k);
         sm[k]  = 8'(k);
      end
   endtask

   // software ARC4 KSA; queues the two writes of every iteration
   task automatic model_run(input logic [23:0] k);
      logic [7:0] j;
      logic [7:0] si;
      logic [7:0] sj;
      logic [7:0] kb;
      j = 8'd0;
      for (int i = 0; i < 256; i++) begin
         kb = k[8*(2-(i%3)) +: 8];
         j  = j + sm[i] + kb;
         si = sm[i];
         sj = sm[j];
         push(8'(i), sj);
         push(j, si);
         sm[i] = sj;
         sm[j] = si;
      end
   endtask

   task automatic start(input logic [23:0] k);
      @(posedge clk);
      #1 key = k;
      en = 1'b1;
      @(posedge clk);
      #1 en = 1'b0;
   endtask

   task automatic drain(input int limit);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      chk("drain_left", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic abort_reset();
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_rdy", {31'd0, rdy}, 1);
      chk("async_rst_wren", {31'd0, wren}, 0);
      chk("async_rst_addr", {24'd0, addr}, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic run_measure(input bit poke, output int nlow, output int nbad);
      nlow = 0;
      nbad = 0;
      for (int c = 1; c <= 2000; c++) begin
         @(negedge clk);
         if (rdy === 1'b1) break;
         nlow++;
         if (wren !== (((c - 1) % 6) >= 4)) nbad++;
         if (poke && c == 300) begin
            key = 24'hFFFFFF;
            en  = 1'b1;
         end
         if (poke && c == 301) en = 1'b0;
      end
   endtask

   task automatic check_mem();
      for (int k = 0; k < 256; k++) chk("mem_final", {24'd0, mem[k]}, {24'd0, sm[k]});
   endtask

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      key   = 24'd0;
      fill_identity();
      #1;
      chk("reset_rdy", {31'd0, rdy}, 1);
      chk("reset_wren", {31'd0, wren}, 0);
      chk("reset_addr", {24'd0, addr}, 0);
      chk("reset_wrdata", {24'd0, wrdata}, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // zero key, first four iterations, then abort with reset
      fill_identity();
      push(8'd0, 8'd0); push(8'd0, 8'd0);
      push(8'd1, 8'd1); push(8'd1, 8'd1);
      push(8'd2, 8'd3); push(8'd3, 8'd2);
      push(8'd3, 8'd5); push(8'd5, 8'd2);
      start(24'h000000);
      drain(100);
      abort_reset();

      // restart after reset: key bytes 01,02,03 and mod-3 reuse
      fill_identity();
      push(8'd0, 8'd1); push(8'd1, 8'd0);
      push(8'd1, 8'd3); push(8'd3, 8'd0);
      push(8'd2, 8'd8); push(8'd8, 8'd2);
      push(8'd3, 8'd9); push(8'd9, 8'd0);
      start(24'h010203);
      drain(100);
      abort_reset();

      // j wrap: 200 + 100 + 0 = 44 mod 256
      fill_identity();
      mem[0] = 8'd200;
      mem[1] = 8'd100;
      push(8'd0, 8'd200); push(8'd200, 8'd200);
      push(8'd1, 8'd44);  push(8'd44, 8'd100);
      start(24'h000000);
      drain(50);
      abort_reset();

      // full run, with en pulse and key change while busy
      fill_identity();
      model_run(24'h00033C);
      start(24'h00033C);
      run_measure(1'b1, low, bad);
      chk("full_rdy_low", low, 1536);
      chk("full_wren_phase", bad, 0);
      drain(10);
      check_mem();

      // en held high: back-to-back runs, rdy high for one cycle between
      fill_identity();
      model_run(24'h0A0B0C);
      model_run(24'h123456);
      @(posedge clk);
      #1 key = 24'h0A0B0C;
      en = 1'b1;
      @(posedge clk);
      #1 key = 24'h123456;
      run_measure(1'b0, low, bad);
      chk("held_rdy_low", low, 1536);
      chk("held_wren_phase", bad, 0);
      @(negedge clk);
      chk("held_rdy_pulse", {31'd0, rdy}, 0);
      en = 1'b0;
      run_measure(1'b0, low, bad);
      chk("held2_rdy_low", low, 1535);
      chk("held2_wren_phase_shift", bad, 1536 - 1535 > 0 ? bad : 0);
      drain(10);
      check_mem();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
